// File: rtl/fryer_ctrl_param.sv
// Air-fryer cooking controller with a configurable number of BCD time digits,
// a configurable mode count and a configurable finish-beep length.
// Buttons are debounced single-cycle pulses; all outputs except power_led are registered.
module fryer_ctrl_param #(
    parameter int unsigned CLK_HZ    = 1000,
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned N_MODES   = 3,
    parameter int unsigned BEEP_SECS = 3,
    parameter int unsigned MODE_W    = $clog2(N_MODES + 1)
) (
    input  logic                  clk_1Khz,
    input  logic                  rst,
    input  logic                  power,
    input  logic                  btn_start,
    input  logic                  btn_reset,
    input  logic                  btn_pause,
    input  logic                  btn_mode,
    input  logic                  btn_inc_lo,
    input  logic                  btn_inc_hi,
    output logic [2:0]            state,
    output logic [MODE_W-1:0]     mode,
    output logic [4*DIGITS-1:0]   disp_time,
    output logic                  disp_blank,
    output logic                  heat_en,
    output logic                  buzzer,
    output logic                  power_led
);

    localparam int unsigned TW     = 4 * DIGITS;
    localparam int unsigned TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BEEP_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLK_HZ / 2);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECS - 1);
    localparam logic [BEEP_W-1:0] BEEP_ONE  = BEEP_W'(1);
    localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(N_MODES);
    localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1);
    localparam logic [TW-1:0]     TIME_ONE  = TW'(1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWork    = 3'd1,
        StFinish  = 3'd2,
        StPrepare = 3'd3,
        StPause   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       time_q, time_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BEEP_W-1:0]   beep_q, beep_d;
    logic                buzzer_q, buzzer_d;
    logic                heat_q;
    logic                blank_q;

    // BCD +1 with carry through every digit; all-9s wraps to all-0s.
    function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with borrow through every digit.
    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // +1 on the most significant digit only, 9 wraps to 0, lower digits untouched.
    function automatic logic [TW-1:0] bcd_ms_inc(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        r = v;
        if (v[TW-1 -: 4] == 4'd9) begin
            r[TW-1 -: 4] = 4'd0;
        end else begin
            r[TW-1 -: 4] = v[TW-1 -: 4] + 4'd1;
        end
        return r;
    endfunction

    // Next-state logic: power-off, then reset, then per-state button/tick handling.
    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        mode_d   = mode_q;
        tick_d   = tick_q;
        beep_d   = beep_q;
        buzzer_d = 1'b0;

        if (!power || (btn_reset && state_q != StIdle)) begin
            state_d = StIdle;
            time_d  = '0;
            mode_d  = '0;
            tick_d  = '0;
            beep_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Start/pause suppress a same-cycle edit, so they also block the wake-up.
                    if (!btn_reset && !btn_start && !btn_pause &&
                        (btn_mode || btn_inc_lo || btn_inc_hi)) begin
                        state_d = StPrepare;
                        mode_d  = MODE_ONE;
                        time_d  = '0;
                    end
                end
                StPrepare, StPause: begin
                    if (btn_start) begin
                        if (time_q != '0) begin
                            state_d = StWork;
                            tick_d  = '0;
                        end
                    end else if (!btn_pause) begin
                        if (btn_mode) begin
                            mode_d = (mode_q == MODE_MAX) ? MODE_ONE : mode_q + MODE_ONE;
                        end
                        if (btn_inc_hi) begin
                            time_d = bcd_ms_inc(time_q);
                        end else if (btn_inc_lo) begin
                            time_d = bcd_inc(time_q);
                        end
                    end
                end
                StWork: begin
                    // Pause wins over a coinciding tick; the counter stays frozen.
                    if (btn_pause && !btn_start) begin
                        state_d = StPause;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        time_d = bcd_dec(time_q);
                        if (time_q == TIME_ONE) begin
                            state_d = StFinish;
                            beep_d  = '0;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                StFinish: begin
                    buzzer_d = (tick_q < TICK_HALF) ? ~buzzer_q : 1'b0;
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (beep_q == BEEP_LAST) begin
                            state_d  = StIdle;
                            time_d   = '0;
                            mode_d   = '0;
                            beep_d   = '0;
                            buzzer_d = 1'b0;
                        end else begin
                            beep_d = beep_q + BEEP_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            time_q   <= '0;
            mode_q   <= '0;
            tick_q   <= '0;
            beep_q   <= '0;
            buzzer_q <= 1'b0;
            heat_q   <= 1'b0;
            blank_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            beep_q   <= beep_d;
            buzzer_q <= buzzer_d;
            heat_q   <= (state_d == StWork);
            blank_q  <= (state_d == StIdle);
        end
    end

    assign state      = state_q;
    assign mode       = mode_q;
    assign disp_time  = time_q;
    assign disp_blank = blank_q;
    assign heat_en    = heat_q;
    assign buzzer     = buzzer_q;
    assign power_led  = power;

endmodule

// File: tb/tb_fryer_ctrl_param.sv
// Bench for fryer_ctrl_param: directed scenarios plus random button traffic,
// checked every cycle against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_fryer_ctrl_param;

    localparam int unsigned CLK_HZ    = 10;
    localparam int unsigned DIGITS    = 2;
    localparam int unsigned N_MODES   = 3;
    localparam int unsigned BEEP_SECS = 3;
    localparam int unsigned MODE_W    = $clog2(N_MODES + 1);
    localparam int          MAXT      = 10 ** DIGITS;
    localparam int          PMS       = 10 ** (DIGITS - 1);

    localparam int unsigned DIGITS2  = 3;
    localparam int unsigned N_MODES2 = 5;
    localparam int unsigned MODE_W2  = $clog2(N_MODES2 + 1);

    logic clk_1Khz = 1'b0;
    logic rst      = 1'b0;

    logic power = 1'b0;
    logic btn_start = 1'b0, btn_reset = 1'b0, btn_pause = 1'b0;
    logic btn_mode = 1'b0, btn_inc_lo = 1'b0, btn_inc_hi = 1'b0;
    logic [2:0]          state;
    logic [MODE_W-1:0]   mode;
    logic [4*DIGITS-1:0] disp_time;
    logic disp_blank, heat_en, buzzer, power_led;

    logic power2 = 1'b1;
    logic s2 = 1'b0, r2 = 1'b0, p2 = 1'b0, m2 = 1'b0, lo2 = 1'b0, hi2 = 1'b0;
    logic [2:0]           state2;
    logic [MODE_W2-1:0]   mode2;
    logic [4*DIGITS2-1:0] time2;
    logic blank2, heat2, buz2, led2;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 idle, 1 work, 2 finish, 3 prepare, 4 pause.
    int m_state, m_time, m_mode, m_sub, m_fin;

    fryer_ctrl_param #(.CLK_HZ(CLK_HZ), .DIGITS(DIGITS), .N_MODES(N_MODES),
                       .BEEP_SECS(BEEP_SECS)) dut (
        .clk_1Khz(clk_1Khz), .rst(rst), .power(power),
        .btn_start(btn_start), .btn_reset(btn_reset), .btn_pause(btn_pause),
        .btn_mode(btn_mode), .btn_inc_lo(btn_inc_lo), .btn_inc_hi(btn_inc_hi),
        .state(state), .mode(mode), .disp_time(disp_time), .disp_blank(disp_blank),
        .heat_en(heat_en), .buzzer(buzzer), .power_led(power_led)
    );

    fryer_ctrl_param #(.CLK_HZ(CLK_HZ), .DIGITS(DIGITS2), .N_MODES(N_MODES2),
                       .BEEP_SECS(1)) dut2 (
        .clk_1Khz(clk_1Khz), .rst(rst), .power(power2),
        .btn_start(s2), .btn_reset(r2), .btn_pause(p2),
        .btn_mode(m2), .btn_inc_lo(lo2), .btn_inc_hi(hi2),
        .state(state2), .mode(mode2), .disp_time(time2), .disp_blank(blank2),
        .heat_en(heat2), .buzzer(buz2), .power_led(led2)
    );

    always #5 clk_1Khz = ~clk_1Khz;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int t);
        logic [31:0] r;
        int v;
        r = '0;
        v = t;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_clear();
        m_state = 0; m_time = 0; m_mode = 0; m_sub = 0; m_fin = 0;
    endtask

    // One clock edge of the reference model, using the inputs sampled at that edge.
    task automatic model_edge();
        int ms;
        if (!power) begin
            model_clear();
        end else if (btn_reset) begin
            if (m_state != 0) model_clear();
        end else begin
            case (m_state)
                0: if (!btn_start && !btn_pause && (btn_mode || btn_inc_lo || btn_inc_hi)) begin
                    m_state = 3; m_mode = 1; m_time = 0;
                end
                3, 4: begin
                    if (btn_start) begin
                        if (m_time != 0) begin m_state = 1; m_sub = 0; end
                    end else if (!btn_pause) begin
                        if (btn_mode) m_mode = m_mode % int'(N_MODES) + 1;
                        if (btn_inc_hi) begin
                            ms = m_time / PMS;
                            m_time = m_time - ms * PMS + ((ms + 1) % 10) * PMS;
                        end else if (btn_inc_lo) begin
                            m_time = (m_time + 1) % MAXT;
                        end
                    end
                end
                1: begin
                    if (btn_pause && !btn_start) begin
                        m_state = 4;
                    end else begin
                        m_sub++;
                        if (m_sub == int'(CLK_HZ)) begin
                            m_sub = 0;
                            m_time--;
                            if (m_time == 0) begin m_state = 2; m_fin = 0; end
                        end
                    end
                end
                2: begin
                    m_fin++;
                    if (m_fin == int'(BEEP_SECS * CLK_HZ)) model_clear();
                end
                default: model_clear();
            endcase
        end
    endtask

    // Buzzer pattern: within each second of FINISH, on at cycles 1,3,5.. of the first half.
    function automatic logic exp_buzzer();
        int p;
        if (m_state != 2 || m_fin < 1) return 1'b0;
        p = (m_fin - 1) % int'(CLK_HZ);
        return (p < int'(CLK_HZ / 2)) && (p % 2 == 0);
    endfunction

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("mode", 32'(mode), 32'(m_mode));
        check("disp_time", 32'(disp_time), to_bcd(m_time));
        check("disp_blank", 32'(disp_blank), 32'(m_state == 0));
        check("heat_en", 32'(heat_en), 32'(m_state == 1));
        check("buzzer", 32'(buzzer), 32'(exp_buzzer()));
        check("power_led", 32'(power_led), 32'(power));
    endtask

    task automatic step();
        @(posedge clk_1Khz);
        model_edge();
        #1;
        {btn_start, btn_reset, btn_pause, btn_mode, btn_inc_lo, btn_inc_hi} = '0;
        {s2, r2, p2, m2, lo2, hi2} = '0;
        compare_all();
    endtask

    // b: 0 start, 1 reset, 2 pause, 3 mode, 4 inc_lo, 5 inc_hi
    task automatic press(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            case (b)
                0: btn_start = 1'b1;
                1: btn_reset = 1'b1;
                2: btn_pause = 1'b1;
                3: btn_mode = 1'b1;
                4: btn_inc_lo = 1'b1;
                default: btn_inc_hi = 1'b1;
            endcase
            step();
        end
    endtask

    task automatic press2(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            case (b)
                0: s2 = 1'b1;
                1: r2 = 1'b1;
                2: p2 = 1'b1;
                3: m2 = 1'b1;
                4: lo2 = 1'b1;
                default: hi2 = 1'b1;
            endcase
            step();
        end
    endtask

    task automatic run_until(input int target, input int limit, output int n);
        n = 0;
        while (state !== 3'(target) && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int hi_cnt;
        logic busy;
        model_clear();

        // Reset values while rst is held low.
        @(posedge clk_1Khz);
        @(posedge clk_1Khz);
        #1;
        compare_all();
        #2;
        rst = 1'b1;
        power = 1'b1;
        step();

        // Set-and-run.
        press(4, 4);
        check("prep_state", 32'(state), 32'd3);
        check("prep_time", 32'(disp_time), 32'h03);
        check("prep_mode", 32'(mode), 32'd1);
        press(0, 1);
        check("work_heat", 32'(heat_en), 32'd1);
        run_until(2, 40, n);
        check("finish_latency", 32'(n), 32'd30);
        n = 0;
        hi_cnt = 0;
        while (state === 3'd2 && n < 40) begin
            if (buzzer === 1'b1) hi_cnt++;
            step();
            n++;
        end
        check("finish_len", 32'(n), 32'd30);
        check("buzzer_highs", 32'(hi_cnt), 32'd9);
        check("after_finish", 32'(state), 32'd0);

        // Carry and wrap at two digits.
        press(4, 1);
        press(4, 9);
        check("inc_to_09", 32'(disp_time), 32'h09);
        press(4, 1);
        check("carry_10", 32'(disp_time), 32'h10);
        press(5, 8);
        press(4, 9);
        check("at_99", 32'(disp_time), 32'h99);
        press(4, 1);
        check("wrap_00", 32'(disp_time), 32'h00);
        press(4, 5);
        press(5, 9);
        check("at_95", 32'(disp_time), 32'h95);
        press(5, 1);
        check("hi_wrap_05", 32'(disp_time), 32'h05);
        press(3, 1);
        check("mode_2", 32'(mode), 32'd2);
        press(3, 2);
        check("mode_wrap", 32'(mode), 32'd1);

        // Simultaneous events.
        press(1, 1);
        check("reset_idle", 32'(state), 32'd0);
        press(4, 1);
        press(0, 1);
        check("start_zero", 32'(state), 32'd3);
        press(4, 3);
        btn_start = 1'b1;
        btn_inc_lo = 1'b1;
        step();
        check("start_lo_state", 32'(state), 32'd1);
        check("start_lo_time", 32'(disp_time), 32'h03);
        for (int i = 0; i < 9; i++) step();
        press(2, 1);
        check("pause_tick_state", 32'(state), 32'd4);
        check("pause_tick_time", 32'(disp_time), 32'h03);
        btn_reset = 1'b1;
        btn_start = 1'b1;
        step();
        check("reset_start", 32'(state), 32'd0);

        // Pause and resume.
        press(4, 3);
        press(5, 1);
        check("at_12", 32'(disp_time), 32'h12);
        press(0, 1);
        for (int i = 0; i < 24; i++) step();
        press(2, 1);
        check("paused", 32'(state), 32'd4);
        check("paused_time", 32'(disp_time), 32'h10);
        for (int i = 0; i < 50; i++) step();
        check("frozen_time", 32'(disp_time), 32'h10);
        press(4, 1);
        check("pause_edit", 32'(disp_time), 32'h11);
        press(0, 1);
        run_until(2, 200, n);
        check("resume_latency", 32'(n), 32'd110);
        press(1, 1);

        // Power abort mid-WORK.
        press(4, 6);
        press(0, 1);
        for (int i = 0; i < 5; i++) step();
        power = 1'b0;
        step();
        check("pwr_state", 32'(state), 32'd0);
        check("pwr_blank", 32'(disp_blank), 32'd1);
        check("pwr_heat", 32'(heat_en), 32'd0);
        check("pwr_time", 32'(disp_time), 32'h00);
        power = 1'b1;
        step();

        // Asynchronous reset mid-FINISH.
        press(4, 2);
        press(0, 1);
        run_until(2, 20, n);
        check("fin1_latency", 32'(n), 32'd10);
        step();
        check("fin_buzz_on", 32'(buzzer), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        compare_all();
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("post_rst_idle", 32'(state), 32'd0);

        // Three-digit, five-mode, one-second-beep instance.
        press2(4, 1);
        press2(3, 4);
        check("d2_mode5", 32'(mode2), 32'd5);
        press2(3, 1);
        check("d2_mode_wrap", 32'(mode2), 32'd1);
        press2(5, 1);
        check("d2_at_100", 32'(time2), 32'h100);
        press2(0, 1);
        for (int i = 0; i < 10; i++) step();
        check("d2_borrow", 32'(time2), 32'h099);
        check("d2_work", 32'(state2), 32'd1);
        press2(1, 1);
        press2(4, 2);
        press2(0, 1);
        n = 0;
        while (state2 !== 3'd2 && n < 20) begin step(); n++; end
        check("d2_fin_latency", 32'(n), 32'd10);
        n = 0;
        while (state2 === 3'd2 && n < 30) begin step(); n++; end
        check("d2_fin_len", 32'(n), 32'd10);

        // Random button traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!power) begin
                if ($urandom_range(0, 4) == 0) power = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                power = 1'b0;
            end
            busy = (m_state == 1 || m_state == 2);
            btn_reset  = ($urandom_range(0, busy ? 600 : 150) == 0);
            btn_start  = ($urandom_range(0, 9) == 0);
            btn_pause  = ($urandom_range(0, busy ? 250 : 30) == 0);
            btn_mode   = ($urandom_range(0, 12) == 0);
            btn_inc_lo = ($urandom_range(0, 3) == 0);
            btn_inc_hi = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fryer_ctrl_param.md
# fryer_ctrl_param

Parametrised air-fryer cooking controller, successor to the fixed 2-digit/3-mode controller. Takes debounced single-cycle button pulses and the power switch; sequences IDLE/PREPARE/WORK/PAUSE/FINISH. Holds a BCD countdown of configurable digit count and a configurable mode range. Drives the seven-segment data path, the heater enable, the dot-matrix state code and a patterned buzzer. Pause/resume keeps the remaining time, and the finish beep length is configurable.

## Interface
- CLK_HZ, 1000: clk_1Khz cycles per second tick.
- DIGITS, 2: BCD time digits (1..4); max time 10^DIGITS-1 s.
- N_MODES, 3: heating modes 1..N_MODES (1..15).
- BEEP_SECS, 3: FINISH duration in seconds.
- MODE_W, $clog2(N_MODES+1): derived mode width.
- clk_1Khz  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- power  in  1  power switch level; 1 = on.
- btn_start, btn_reset, btn_pause, btn_mode, btn_inc_lo, btn_inc_hi  in  1 each  debounced one-cycle pulses.
- state  out  3  IDLE=0, WORK=1, FINISH=2, PREPARE=3, PAUSE=4.
- mode  out  MODE_W  current mode; 0 = none.
- disp_time  out  4*DIGITS  BCD time, LS digit in [3:0].
- disp_blank  out  1  1 = segments off.
- heat_en  out  1  high only in WORK.
- buzzer  out  1  buzzer drive.
- power_led  out  1  equals power (combinational).

## Operation
- Reset values: state IDLE, time 0, mode 0, tick counter 0, beep counter 0, buzzer 0, heat_en 0, disp_blank 1.
- power=0: synchronously forces IDLE and clears time, mode, counters and buzzer. This holds every cycle the switch is off, and all buttons are ignored.
- Button priority within one cycle: btn_reset > btn_start > btn_pause > edits (btn_mode, btn_inc_hi, btn_inc_lo). A start or pause pulse drops any edit pulse arriving in the same cycle.
- IDLE: btn_mode, btn_inc_lo or btn_inc_hi moves to PREPARE with mode=1 and time=0. The waking pulse itself does not edit. All other buttons are ignored.
- PREPARE/PAUSE edits:
  - btn_mode: cycles 1..N_MODES and wraps to 1.
  - btn_inc_lo: BCD +1 with carry across all digits; the all-9s value wraps to all-0s.
  - btn_inc_hi: +1 on the MS digit only, 9->0, no carry.
  - btn_inc_hi and btn_inc_lo in the same cycle: only inc_hi applies. btn_mode applies independently of either.
- btn_start in PREPARE/PAUSE:
  - Time≠0: go to WORK and clear the tick counter.
  - Time=0: ignored.
- btn_reset in any non-IDLE state: go to IDLE with time 0, mode 0 and buzzer 0.
- WORK:
  - The tick counter counts 0..CLK_HZ-1. On the cycle it wraps, time decrements by 1 in BCD with borrow.
  - If the decrement takes time 1->0, state becomes FINISH on the same edge.
  - btn_pause moves to PAUSE. Time is retained, the tick counter is frozen and no decrement happens that cycle even if a tick coincides.
- PAUSE: edits modify the remaining time. btn_start resumes with the tick counter cleared.
- FINISH:
  - Tick counter free-runs. buzzer toggles every cycle while tick < CLK_HZ/2 and is 0 otherwise.
  - After BEEP_SECS full seconds, go to IDLE with mode 0, time 0 and buzzer 0.
  - Only btn_reset and power=0 act in FINISH.
- disp_blank = (state==IDLE) | ~power. disp_time always shows the live time register.
- No divide/modulo hardware; all time arithmetic is BCD.

## Timing
- All outputs are registered except power_led. A button sampled at edge k takes effect at k.
- WORK is entered at edge k, and each second's decrement lands at edges k+CLK_HZ·n.
- For a start value of N s, FINISH asserts exactly N·CLK_HZ cycles after state first reads WORK, given no pauses.
- A pause of P cycles delays FINISH by P plus the discarded partial second, since the tick counter is cleared on resume.
- FINISH lasts exactly BEEP_SECS·CLK_HZ cycles.
- Async rst mid-operation returns all outputs to their reset values immediately. The first state change after rst release needs a button pulse.

## Test plan
- Set-and-run (CLK_HZ=10 for sim): rst, power=1, btn_inc_lo ×4 → PREPARE, disp_time=0x03, mode=1; btn_start → WORK, heat_en=1. Expect FINISH exactly 30 cycles later, buzzer toggling 5 of every 10 cycles, then IDLE after 30 cycles.
- Carry/wrap at DIGITS=2: btn_inc_lo from 0x09 → 0x10; from 0x99 → 0x00; btn_inc_hi from 0x95 → 0x05. btn_mode ×3 from 1 → 1 (N_MODES=3).
- Pause/resume: start at 0x12, pause after 25 cycles → PAUSE with time 0x10 frozen 50 cycles. Add btn_inc_lo → 0x11, btn_start → FINISH 110 cycles after resume.
- Simultaneous events: pause coinciding with a tick leaves time unchanged. Start with time 0 stays in PREPARE. Start+inc_lo in the same cycle goes to WORK with time unchanged. Reset+start goes to IDLE.
- Power/reset abort: power=0 mid-WORK → IDLE, disp_blank=1, heat_en=0, time 0. rst low mid-FINISH → buzzer 0 and state 0 immediately.
- Parameter sweep DIGITS=3, N_MODES=5, BEEP_SECS=1: borrow 0x100→0x099, mode wraps 5→1, and FINISH lasts CLK_HZ cycles.
